// File: rtl/uart_tx.sv
// UART transmitter, one bit per clk: start, LSB-first data, optional parity,
// stop bits, optional idle gap; ready/valid upstream, done pulse, line enable.
module uart_tx #(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY_BIT = "none",
    parameter int    STOP_BITS  = 1,
    parameter int    IDLE_GAP   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_data_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_oe,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW      = $clog2(DATA_BITS + 1);
    localparam bit PAR_EN  = (PARITY_BIT != "none");
    localparam bit PAR_ODD = (PARITY_BIT == "odd");

    generate
        if (PARITY_BIT != "none" && PARITY_BIT != "even" && PARITY_BIT != "odd") begin : g_bad_par
            $error("uart_tx: PARITY_BIT must be none, even or odd");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1..2");
        end
        if (IDLE_GAP < 0 || IDLE_GAP > 15) begin : g_bad_gap
            $error("uart_tx: IDLE_GAP must be 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic [3:0]           r_gap_cnt;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_oe;
    logic                 r_busy;
    logic                 r_done;

    logic w_last_stop;
    logic w_last_gap;
    logic w_ready;
    logic w_accept;

    assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == 1'b0);
    assign w_last_gap  = (r_state == S_GAP) && (r_gap_cnt == 4'd0);

    // Ready opens in the last occupied cycle so the next start bit follows
    // with no bubble.
    assign w_ready  = (r_state == S_IDLE) ||
                      ((IDLE_GAP == 0) ? w_last_stop : w_last_gap);
    assign w_accept = tx_data_valid && w_ready && !rst;

    assign tx_ready = w_ready && !rst;
    assign tx       = r_tx;
    assign tx_oe    = r_oe;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_gap_cnt  <= 4'd0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_stop;
            if (w_accept) begin
                r_shift <= tx_data;
                r_par   <= ^tx_data;
                r_state <= S_START;
                r_tx    <= 1'b0;
                r_oe    <= 1'b1;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_START: begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= BW'(DATA_BITS - 1);
                    end
                    S_DATA: begin
                        if (r_bit_cnt == '0) begin
                            if (PAR_EN) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par ^ PAR_ODD;
                            end else begin
                                r_state    <= S_STOP;
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'(STOP_BITS - 1);
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_state    <= S_STOP;
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'(STOP_BITS - 1);
                    end
                    S_STOP: begin
                        if (r_stop_cnt == 1'b0) begin
                            r_tx <= 1'b1;
                            r_oe <= 1'b0;
                            if (IDLE_GAP > 0) begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= 4'(IDLE_GAP - 1);
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt - 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == 4'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
